// File: rtl/wb_burst_fetch.sv
// wb_burst_fetch: Wishbone linear-burst read master streaming SRAM words into a FWFT FIFO
module wb_burst_fetch #(
  parameter int BURST_LEN = 8,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:2]               base_addr,
  input  logic [CNT_BITS-1:0]       word_count,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      rd_en,
  output logic [31:0]               rd_data,
  output logic                      rd_empty,
  output logic [FIFO_ADDR_BITS:0]   rd_level,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic [31:2]               wbm_addr_o,
  output logic [2:0]                wbm_cti_o,
  output logic [1:0]                wbm_bte_o,
  output logic [3:0]                wbm_sel_o,
  output logic                      wbm_we_o,
  input  logic [31:0]               wbm_data_i,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i
);
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int LW = FIFO_ADDR_BITS + 2;
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, FINISH} state_t;
  state_t state, state_d;
  logic [CNT_BITS-1:0] remaining;
  logic [BW-1:0] beat_cnt, beat_d, beats;
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [31:0] mem [DEPTH];
  logic accept, pop, push, fits, last;
  assign accept = state == IDLE && start;
  assign pop = rd_en && !rd_empty && !accept;
  assign push = state == BURST && wbm_ack_i && !wbm_err_i;
  assign last = beat_cnt == BW'(1);
  assign beats = remaining >= CNT_BITS'(BURST_LEN) ? BW'(BURST_LEN) : BW'(remaining);
  // Space test counts this cycle's pop so a burst can launch on the freeing edge
  assign fits = LW'(rd_level) - LW'(pop) + LW'(beats) <= LW'(DEPTH);
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign rd_empty = rd_level == '0;
  assign rd_data = rd_empty ? '0 : mem[rd_ptr];
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_bte_o = 2'b00;
  assign wbm_sel_o = 4'b1111;
  assign wbm_we_o = 1'b0;
  always_comb begin
    state_d = state;
    beat_d = beat_cnt;
    case (state)
      IDLE: if (start) state_d = word_count == '0 ? FINISH : WAIT_SPACE;
      WAIT_SPACE: if (fits) begin
        state_d = BURST;
        beat_d = beats;
      end
      BURST: if (wbm_err_i) state_d = FINISH;
        else if (wbm_ack_i) begin
          beat_d = beat_cnt - 1'b1;
          if (last) state_d = remaining == CNT_BITS'(1) ? FINISH : WAIT_SPACE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      beat_cnt <= '0;
      remaining <= '0;
      err <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_addr_o <= '0;
      wbm_cti_o <= 3'b000;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_level <= '0;
    end else begin
      state <= state_d;
      beat_cnt <= beat_d;
      wbm_cyc_o <= state_d == BURST;
      wbm_cti_o <= state_d != BURST ? 3'b000 : beat_d == BW'(1) ? 3'b111 : 3'b010;
      if (accept) begin
        wbm_addr_o <= base_addr;
        remaining <= word_count;
        err <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        rd_level <= '0;
      end else begin
        if (state == BURST && wbm_err_i) err <= 1'b1;
        if (push) begin
          wbm_addr_o <= wbm_addr_o + 30'd1;
          remaining <= remaining - CNT_BITS'(1);
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        rd_level <= rd_level + (FIFO_ADDR_BITS+1)'(push) - (FIFO_ADDR_BITS+1)'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wbm_data_i;
endmodule

// File: tb/tb_wb_burst_fetch.sv
// tb_wb_burst_fetch: scoreboard bench with a word-addressed slave model and a randomized consumer
module tb_wb_burst_fetch;
  localparam int BL = 8, FAB = 4, CB = 16;
  logic clk = 0, rst = 0, start = 0, rd_en = 0;
  logic busy, done, err, rd_empty;
  logic [31:2] base_addr = '0, wbm_addr_o;
  logic [CB-1:0] word_count = '0;
  logic [31:0] rd_data, wbm_data_i = '0;
  logic [FAB:0] rd_level;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i = 0, wbm_err_i = 0;
  logic [2:0] wbm_cti_o;
  logic [1:0] wbm_bte_o;
  logic [3:0] wbm_sel_o;
  typedef struct packed {logic [29:0] addr; logic [2:0] cti;} beat_t;
  logic [31:0] data_q[$];
  beat_t beat_q[$];
  int n_checks = 0, n_pass = 0;
  int ws = 1, err_beat = 0, pop_mode = 0, ws_cnt = 0, beat_no = 0;
  logic prev_cyc = 0, prev_term = 0;
  logic [29:0] prev_addr = '0;

  wb_burst_fetch #(.BURST_LEN(BL), .FIFO_ADDR_BITS(FAB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .rd_level(rd_level), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_addr_o(wbm_addr_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_data_i(wbm_data_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [29:0] a);
    return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(string name, logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_mode == 1) rd_en = 1;
    else if (pop_mode == 2) rd_en = 1'($urandom_range(0, 1));
  endtask

  // Expected stream: words base..base+count-1 (mod 2^30), split into BL-beat bursts
  task automatic start_xfer(logic [29:0] base, int count);
    base_addr = base;
    word_count = CB'(count);
    start = 1;
    data_q.delete();
    beat_q.delete();
    for (int i = 0; i < count; i++) begin
      logic [29:0] a;
      int len;
      a = base + 30'(i);
      len = (count - (i / BL) * BL) < BL ? count - (i / BL) * BL : BL;
      data_q.push_back(mem_word(a));
      beat_q.push_back('{a, (i % BL == len - 1) ? 3'b111 : 3'b010});
    end
    tick();
    start = 0;
  endtask

  task automatic wait_done(int limit, output int c);
    c = 0;
    while (!done && c < limit) begin
      tick();
      c++;
    end
    if (!done) fail("done_timeout", 32'(c));
  endtask

  task automatic drain();
    int c;
    c = 0;
    pop_mode = 1;
    rd_en = 1;
    while (!rd_empty && c < 100) begin
      tick();
      c++;
    end
    pop_mode = 0;
    rd_en = 0;
    check("fifo_drained", 32'(data_q.size()), 0);
  endtask

  // Slave: acks every ws-th cycle of cyc, optionally errors on beat err_beat
  always @(posedge clk) begin
    #1;
    wbm_ack_i = 0;
    wbm_err_i = 0;
    if (!busy) beat_no = 0;
    if (!wbm_cyc_o) ws_cnt = 0;
    else begin
      ws_cnt++;
      if (ws_cnt >= ws) begin
        ws_cnt = 0;
        beat_no++;
        if (beat_no == err_beat) wbm_err_i = 1;
        else wbm_ack_i = 1;
      end
    end
    wbm_data_i = mem_word(wbm_addr_o);
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_cyc = 0;
      prev_term = 0;
    end else begin
      if (rd_en && !rd_empty) begin
        if (data_q.size() == 0) fail("rd_data_unexpected", rd_data);
        else check("rd_data", rd_data, data_q.pop_front());
      end
      if (wbm_cyc_o && (wbm_ack_i || wbm_err_i)) begin
        if (beat_q.size() == 0) fail("beat_unexpected", 32'(wbm_addr_o));
        else begin
          int n;
          beat_t b;
          n = beat_q.size();
          b = beat_q.pop_front();
          check("beat_addr", 32'(wbm_addr_o), 32'(b.addr));
          check("bus_const", 32'({wbm_we_o, wbm_bte_o, wbm_sel_o}), 32'h0F);
          if (wbm_err_i) begin
            repeat (n) if (data_q.size() > 0) data_q.delete(data_q.size() - 1);
            beat_q.delete();
          end else check("beat_cti", 32'(wbm_cti_o), 32'(b.cti));
        end
      end
      if (wbm_cyc_o && prev_cyc && !prev_term) check("addr_hold", 32'(wbm_addr_o), 32'(prev_addr));
      prev_cyc = wbm_cyc_o;
      prev_term = wbm_ack_i || wbm_err_i;
      prev_addr = wbm_addr_o;
    end
  end

  task automatic check_reset_values(string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_cyc"}, 32'({wbm_cyc_o, wbm_stb_o}), 0);
    check({tag, "_addr"}, 32'(wbm_addr_o), 0);
    check({tag, "_cti"}, 32'(wbm_cti_o), 0);
    check({tag, "_empty"}, 32'(rd_empty), 1);
    check({tag, "_level"}, 32'(rd_level), 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #12;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1;
    tick();

    pop_mode = 1;
    start_xfer(30'h100, 8);
    check("busy_after_start", 32'(busy), 1);
    check("cyc_after_start", 32'(wbm_cyc_o), 0);
    tick();
    check("cyc_rise", 32'(wbm_cyc_o), 1);
    wait_done(100, c);
    check("done_latency", 32'(c), 8);
    check("busy_with_done", 32'(busy), 1);
    check("cyc_at_done", 32'(wbm_cyc_o), 0);
    tick();
    check("done_one_cycle", 32'(done), 0);
    check("busy_fall", 32'(busy), 0);
    drain();

    start_xfer(30'h55, 0);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 1);
    check("zero_cyc", 32'(wbm_cyc_o), 0);
    tick();
    check("zero_done_end", 32'(done), 0);
    check("zero_busy_end", 32'(busy), 0);
    check("zero_cyc_end", 32'(wbm_cyc_o), 0);

    start_xfer(30'h200, 20);
    c = 0;
    while (rd_level != 16 && c < 100) begin
      tick();
      c++;
    end
    check("level_full", 32'(rd_level), 16);
    repeat (4) tick();
    check("withheld_cyc", 32'(wbm_cyc_o), 0);
    check("withheld_level", 32'(rd_level), 16);
    rd_en = 1;
    repeat (3) tick();
    rd_en = 0;
    repeat (3) tick();
    check("still_withheld", 32'(wbm_cyc_o), 0);
    check("level_13", 32'(rd_level), 13);
    rd_en = 1;
    tick();
    rd_en = 0;
    check("third_burst", 32'(wbm_cyc_o), 1);
    check("level_12", 32'(rd_level), 12);
    wait_done(100, c);
    drain();

    err_beat = 3;
    start_xfer(30'h3F0, 8);
    wait_done(100, c);
    check("err_set", 32'(err), 1);
    check("err_level", 32'(rd_level), 2);
    check("err_cyc", 32'(wbm_cyc_o), 0);
    err_beat = 0;
    tick();
    drain();
    pop_mode = 1;
    start_xfer(30'h77, 5);
    check("err_cleared", 32'(err), 0);
    wait_done(100, c);
    drain();

    ws = 3;
    pop_mode = 2;
    start_xfer(30'($urandom), 12);
    repeat (4) tick();
    check("busy_before_restart", 32'(busy), 1);
    base_addr = 30'h1234;
    word_count = 3;
    start = 1;
    tick();
    start = 0;
    wait_done(500, c);
    drain();

    ws = 1;
    pop_mode = 0;
    start_xfer(30'h3000, 16);
    repeat (3) tick();
    check("cyc_before_reset", 32'(wbm_cyc_o), 1);
    #3;
    rst = 0;
    #1;
    check_reset_values("async_reset");
    data_q.delete();
    beat_q.delete();
    @(posedge clk);
    #1;
    rst = 1;
    tick();

    for (int it = 0; it < 8; it++) begin
      logic [29:0] b;
      b = (it % 2 == 1) ? 30'h3FFFFFF0 + 30'($urandom_range(0, 15)) : 30'($urandom);
      ws = $urandom_range(1, 3);
      pop_mode = 2;
      start_xfer(b, $urandom_range(0, 40));
      wait_done(3000, c);
      tick();
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
